// File: rtl/latch_tx.sv
// latch_tx: serial writer for a shift-register / store-latch output bank.
// A parallel word accepted on a one-cycle start is shifted out on sd with a
// divided serial clock sck (DIV clk cycles per half-period), after which the
// store strobe st is held for DIV cycles and done pulses for one cycle.
// Optional build macro: LATCH_TX_LSB_FIRST_EN selects LSB-first bit order;
// when undefined the word is sent MSB first. Timing is identical either way.
module latch_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic             sd,
    output logic             sck,
    output logic             st
);

    // Counter widths, never narrower than one bit so DIV=1 / WIDTH=1 still work.
    localparam int PW = (DIV   > 1) ? $clog2(DIV)   : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_STROBE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;   // bits still waiting behind sd
    logic [PW-1:0]     phase_q, phase_d;   // position inside an sck half-period / strobe
    logic [BW-1:0]     bit_q,   bit_d;     // index of the bit currently on sd
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              sd_q,    sd_d;
    logic              sck_q,   sck_d;
    logic              st_q,    st_d;

    // Bit-order selection: which bit goes out first and how the remainder moves up.
    logic              load_bit;
    logic [WIDTH-1:0]  load_rest;
    logic              next_bit;
    logic [WIDTH-1:0]  next_rest;

`ifdef LATCH_TX_LSB_FIRST_EN
    // LSB first: the low end of the register feeds sd.
    always_comb begin
        load_bit  = din[0];
        load_rest = din >> 1;
        next_bit  = shreg_q[0];
        next_rest = shreg_q >> 1;
    end
`else
    // MSB first: the high end of the register feeds sd.
    always_comb begin
        load_bit  = din[WIDTH-1];
        load_rest = din << 1;
        next_bit  = shreg_q[WIDTH-1];
        next_rest = shreg_q << 1;
    end
`endif

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sd_d    = sd_q;
        sck_d   = sck_q;
        st_d    = st_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                sck_d  = 1'b0;
                st_d   = 1'b0;
                sd_d   = 1'b0;
                if (start) begin
                    // First bit goes straight onto sd so it is stable for the whole low phase.
                    state_d = S_SHIFT;
                    shreg_d = load_rest;
                    sd_d    = load_bit;
                    phase_d = '0;
                    bit_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            S_SHIFT: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (!sck_q) begin
                        // End of low half: raise sck, the chain samples sd here.
                        sck_d = 1'b1;
                    end else begin
                        // End of high half: falling sck is where sd advances.
                        sck_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_STROBE;
                            st_d    = 1'b1;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            sd_d    = next_bit;
                            shreg_d = next_rest;
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_STROBE: begin
                // sd keeps the last bit and sck stays low while the latch loads.
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = S_IDLE;
                    st_d    = 1'b0;
                    busy_d  = 1'b0;
                    sd_d    = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                shreg_d = '0;
                phase_d = '0;
                bit_d   = '0;
                busy_d  = 1'b0;
                sd_d    = 1'b0;
                sck_d   = 1'b0;
                st_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any partial word without a strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sd_q    <= 1'b0;
            sck_q   <= 1'b0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sd_q    <= sd_d;
            sck_q   <= sck_d;
            st_q    <= st_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sd   = sd_q;
    assign sck  = sck_q;
    assign st   = st_q;

endmodule
